// File: rtl/sram_access_arbiter_pkg.sv
// sram_access_arbiter_pkg: shared state encoding and port indices for the SRAM access arbiter.
package sram_access_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic state_t busy_of(input logic port);
        return (port == PORT1) ? BUSY1 : BUSY0;
    endfunction
endpackage

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester ports (MEM stage, fetch) and SRAM controller side of the arbiter.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_wr_en;
    logic              p0_rd_en;
    logic [ADDR_W-1:0] p0_address;
    logic [DATA_W-1:0] p0_write_data;
    logic [DATA_W-1:0] p0_read_data;
    logic              p0_ready;
    logic              p1_rd_en;
    logic [ADDR_W-1:0] p1_address;
    logic [DATA_W-1:0] p1_read_data;
    logic              p1_ready;
    logic              ctrl_wr_en;
    logic              ctrl_rd_en;
    logic [ADDR_W-1:0] ctrl_address;
    logic [DATA_W-1:0] ctrl_write_data;
    logic [DATA_W-1:0] ctrl_read_data;
    logic              ctrl_ready;

    modport slave (
        input  p0_wr_en, p0_rd_en, p0_address, p0_write_data, p1_rd_en, p1_address,
               ctrl_read_data, ctrl_ready,
        output p0_read_data, p0_ready, p1_read_data, p1_ready,
               ctrl_wr_en, ctrl_rd_en, ctrl_address, ctrl_write_data
    );

    modport master (
        output p0_wr_en, p0_rd_en, p0_address, p0_write_data, p1_rd_en, p1_address,
               ctrl_read_data, ctrl_ready,
        input  p0_read_data, p0_ready, p1_read_data, p1_ready,
               ctrl_wr_en, ctrl_rd_en, ctrl_address, ctrl_write_data
    );
endinterface

// File: rtl/sram_access_arbiter_rr.sv
// rr_arbiter_2: combinational two-way grant, round-robin on last_grant or fixed priority to port 0.
module rr_arbiter_2
    import sram_access_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt
);
    always_comb begin
        gnt_valid = req0 | req1;
        gnt       = (req0 & req1) ? (RR_EN ? ~last_grant : PORT0) : (req1 ? PORT1 : PORT0);
    end
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one SRAM controller between the MEM stage (port 0) and fetch (port 1),
// one access at a time with a one-cycle gap so the controller returns idle between commands.
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    sram_access_arbiter_if.slave  bus
);
    state_t            state;
    logic              first_cycle;
    logic              last_grant;
    logic              cmd_wr;
    logic              cmd_rd;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              req0;
    logic              req1;
    logic              gnt_valid;
    logic              gnt;
    logic              done;

    assign req0 = bus.p0_wr_en | bus.p0_rd_en;
    assign req1 = bus.p1_rd_en;

    rr_arbiter_2 #(.RR_EN(RR_EN)) u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt)
    );

    // The controller's ready in the first BUSY cycle still reflects its previous idle state.
    assign done = (state == BUSY0 || state == BUSY1) & bus.ctrl_ready & ~first_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            first_cycle <= 1'b0;
            last_grant  <= PORT1;
            cmd_wr      <= 1'b0;
            cmd_rd      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    state       <= busy_of(gnt);
                    first_cycle <= 1'b1;
                    last_grant  <= gnt;
                    cmd_wr      <= (gnt == PORT0) & bus.p0_wr_en;
                    cmd_rd      <= (gnt == PORT1) | ~bus.p0_wr_en;
                    lat_addr    <= (gnt == PORT0) ? bus.p0_address : bus.p1_address;
                    if (gnt == PORT0) lat_wdata <= bus.p0_write_data;
                end
                BUSY0, BUSY1: begin
                    first_cycle <= 1'b0;
                    if (done) begin
                        state  <= GAP;
                        cmd_wr <= 1'b0;
                        cmd_rd <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ctrl_wr_en      = cmd_wr;
    assign bus.ctrl_rd_en      = cmd_rd;
    assign bus.ctrl_address    = lat_addr;
    assign bus.ctrl_write_data = lat_wdata;
    assign bus.p0_ready        = ~req0 | (state == BUSY0 & done);
    assign bus.p1_ready        = ~req1 | (state == BUSY1 & done);
    assign bus.p0_read_data    = bus.ctrl_read_data;
    assign bus.p1_read_data    = bus.ctrl_read_data;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: round-robin and fixed-priority arbiters against a latency-programmable SRAM model.
module tb_sram_access_arbiter;
    import sram_access_arbiter_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fbus ();

    sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) fdut (.clk(clk), .rst(rst), .bus(fbus));

    int checks = 0;
    int errors = 0;
    int lat = 2;
    int cnt = 0;
    int fcnt = 0;
    int fp0 = 0;
    int fp1 = 0;
    bit prev_done = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    int got_order[$];
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    function automatic logic [31:0] init_val(input int i);
        return (i == 64) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM controller model: ready drops as soon as a command appears, returns after lat cycles.
    assign bus.ctrl_ready     = !(bus.ctrl_wr_en || bus.ctrl_rd_en) || cnt >= lat;
    assign bus.ctrl_read_data = mem[bus.ctrl_address[11:2]];
    assign fbus.ctrl_ready     = !(fbus.ctrl_wr_en || fbus.ctrl_rd_en) || fcnt >= 2;
    assign fbus.ctrl_read_data = 32'h0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cnt  <= 0;
                fcnt <= 0;
            end else begin
                if (bus.ctrl_wr_en && cnt >= lat) mem[bus.ctrl_address[11:2]] <= bus.ctrl_write_data;
                cnt  <= ((bus.ctrl_wr_en || bus.ctrl_rd_en) && cnt < lat) ? cnt + 1 : 0;
                fcnt <= ((fbus.ctrl_wr_en || fbus.ctrl_rd_en) && fcnt < 2) ? fcnt + 1 : 0;
            end
        end
    end

    task automatic serve(input int k);
        exp_t e;
        string p;
        int sz;
        p  = (k == 1) ? "p1_" : "p0_";
        sz = (k == 1) ? q1.size() : q0.size();
        if (sz == 0) begin
            chk({p, "sb_empty"}, 32'(sz), 32'd1);
            return;
        end
        e = (k == 1) ? q1.pop_front() : q0.pop_front();
        got_order.push_back(k);
        prev_done = 1'b1;
        chk({p, "addr"}, bus.ctrl_address, e.addr);
        chk({p, "wr_en"}, 32'(bus.ctrl_wr_en), 32'(e.we));
        chk({p, "rd_en"}, 32'(bus.ctrl_rd_en), 32'(!e.we));
        if (e.we) chk({p, "wdata"}, bus.ctrl_write_data, e.data);
        else chk({p, "rdata"}, (k == 1) ? bus.p1_read_data : bus.p0_read_data, e.data);
        if (k == 0 && bus.p1_rd_en) chk("p1_wait", 32'(bus.p1_ready), 32'd0);
        if (k == 1 && (bus.p0_wr_en || bus.p0_rd_en)) chk("p0_wait", 32'(bus.p0_ready), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_done) chk("gap_idle", 32'(bus.ctrl_wr_en | bus.ctrl_rd_en), 32'd0);
                prev_done = 1'b0;
                if ((bus.p0_wr_en || bus.p0_rd_en) && bus.p0_ready) serve(0);
                if (bus.p1_rd_en && bus.p1_ready) serve(1);
                if (fbus.p0_rd_en && fbus.p0_ready) fp0++;
                if (fbus.p1_rd_en && fbus.p1_ready) fp1++;
            end
        end
    end

    task automatic p0_access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                             output int n);
        exp_t e;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : ref_mem[a[11:2]];
        if (we) ref_mem[a[11:2]] = d;
        q0.push_back(e);
        bus.p0_wr_en      = we;
        bus.p0_rd_en      = re;
        bus.p0_address    = a;
        bus.p0_write_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.p0_ready && n < 200);
        if (!bus.p0_ready) chk("p0_timeout", 32'(bus.p0_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic p1_access(input logic [31:0] a, output int n);
        exp_t e;
        e.we   = 1'b0;
        e.addr = a;
        e.data = ref_mem[a[11:2]];
        q1.push_back(e);
        bus.p1_rd_en   = 1'b1;
        bus.p1_address = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.p1_ready && n < 200);
        if (!bus.p1_ready) chk("p1_timeout", 32'(bus.p1_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic p0_idle();
        bus.p0_wr_en = 1'b0;
        bus.p0_rd_en = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, n1, w;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        bus.p0_wr_en = 0; bus.p0_rd_en = 0; bus.p0_address = 0; bus.p0_write_data = 0;
        bus.p1_rd_en = 0; bus.p1_address = 0;
        fbus.p0_wr_en = 0; fbus.p0_rd_en = 0; fbus.p0_address = 0; fbus.p0_write_data = 0;
        fbus.p1_rd_en = 0; fbus.p1_address = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p0_ready", 32'(bus.p0_ready), 32'd1);
        chk("rst_p1_ready", 32'(bus.p1_ready), 32'd1);
        chk("rst_ctrl_rd", 32'(bus.ctrl_rd_en), 32'd0);
        chk("rst_ctrl_wr", 32'(bus.ctrl_wr_en), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_fp_ready", 32'({fbus.p0_ready, fbus.p1_ready}), 32'd3);
        @(posedge clk);
        #1 rst = 1'b0;
        settle();

        // single fetch read, 4-cycle controller
        lat = 4;
        p1_access(32'h100, n1);
        chk("p1_read_cycles", 32'(n1), 32'd6);
        bus.p1_rd_en = 1'b0;
        @(negedge clk);
        chk("gap_state", 32'(dut.state), 32'(GAP));
        chk("gap_rd_en", 32'(bus.ctrl_rd_en), 32'd0);
        chk("gap_p1_ready", 32'(bus.p1_ready), 32'd1);
        @(negedge clk);
        chk("after_gap_state", 32'(dut.state), 32'(IDLE));

        // simultaneous write on port 0 and fetch read: port 0 first
        lat = 2;
        settle();
        got_order.delete();
        fork
            begin p0_access(1'b1, 1'b0, 32'h40, 32'h12345678, n0); p0_idle(); end
            begin p1_access(32'h80, n1); bus.p1_rd_en = 1'b0; end
        join
        settle();
        chk("contend_cnt", 32'(got_order.size()), 32'd2);
        for (int i = 0; i < got_order.size() && i < 2; i++) chk("contend_order", 32'(got_order[i]), 32'(i));

        // both ports hold requests for six accesses
        lat = 1;
        got_order.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) p0_access(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i), n0);
                p0_idle();
            end
            begin
                for (int i = 0; i < 3; i++) p1_access(32'h10 + 32'(4 * i), n1);
                bus.p1_rd_en = 1'b0;
            end
        join
        settle();
        chk("rr_cnt", 32'(got_order.size()), 32'd6);
        for (int i = 0; i < got_order.size() && i < 6; i++) chk("rr_order", 32'(got_order[i]), 32'(i % 2));

        // write+read together is a write; then read back written data on both ports
        p0_access(1'b1, 1'b1, 32'h400, 32'hFEEDF00D, n0);
        p0_idle();
        p1_access(32'h400, n1);
        bus.p1_rd_en = 1'b0;
        p1_access(32'h304, n1);
        bus.p1_rd_en = 1'b0;
        p0_access(1'b0, 1'b1, 32'h40, 32'h0, n0);
        p0_idle();

        // controller ready in the first BUSY cycle must not complete the access
        lat = 0;
        settle();
        p0_access(1'b0, 1'b1, 32'h308, 32'h0, n0);
        p0_idle();
        chk("first_cycle_ignored", 32'(n0), 32'd3);

        // reset in the middle of a port 0 access
        lat = 10;
        settle();
        bus.p0_rd_en   = 1'b1;
        bus.p0_address = 32'h44;
        repeat (3) @(negedge clk);
        chk("mid_busy_state", 32'(dut.state), 32'(BUSY0));
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        chk("arst_ctrl_rd", 32'(bus.ctrl_rd_en), 32'd0);
        chk("arst_ctrl_addr", bus.ctrl_address, 32'h0);
        chk("arst_p0_ready_req", 32'(bus.p0_ready), 32'd0);
        bus.p0_rd_en = 1'b0;
        #1;
        chk("arst_p0_ready_idle", 32'(bus.p0_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        lat = 2;
        settle();

        // fixed priority: port 0 wins every contended grant
        fp0 = 0;
        fp1 = 0;
        fbus.p0_rd_en = 1'b1; fbus.p0_address = 32'h20;
        fbus.p1_rd_en = 1'b1; fbus.p1_address = 32'h24;
        w = 0;
        while (fp0 < 6 && w < 200) begin @(negedge clk); w++; end
        chk("fp_p0_served", 32'(fp0 >= 6), 32'd1);
        chk("fp_p1_starved", 32'(fp1), 32'd0);
        @(posedge clk);
        #1 fbus.p0_rd_en = 1'b0;
        w = 0;
        while (fp1 < 1 && w < 50) begin @(negedge clk); w++; end
        chk("fp_p1_served", 32'(fp1), 32'd1);
        @(posedge clk);
        #1 fbus.p1_rd_en = 1'b0;
        settle();

        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
